// File: rtl/fft_output_serializer_if.sv
// Handshake bundle between a parallel FFT frame producer and a serial sample consumer.
// The slave view is the serializer; the master view is whatever feeds frames and drains samples.
interface fft_output_serializer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);
  localparam int IDX_W = $clog2(N_SAMPLES);

  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES];
  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] send_msg;
  logic [IDX_W-1:0]     send_idx;
  logic                 send_last;
  logic                 send_val;
  logic                 send_rdy;

  modport slave (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_idx, send_last, send_val
  );

  modport master (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_idx, send_last, send_val
  );
endinterface

// File: rtl/fft_output_serializer.sv
// Captures one parallel FFT frame and streams it out one bin per cycle.
// HALF_SPECTRUM trims the stream to bins 0..N/2 for real-input transforms.
// All sample outputs come from registers; recv_rdy is the only combinational
// output, so a new frame can be taken on the same edge as the final bin.
module fft_output_serializer #(
  parameter int BIT_WIDTH     = 32,
  parameter int N_SAMPLES     = 8,
  parameter int HALF_SPECTRUM = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_output_serializer_if.slave intf
);
  localparam int               OUT_COUNT = (HALF_SPECTRUM != 0) ? (N_SAMPLES / 2 + 1) : N_SAMPLES;
  localparam int               IDX_W     = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(OUT_COUNT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [BIT_WIDTH-1:0] frame [N_SAMPLES];
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [BIT_WIDTH-1:0] send_msg_q;
  logic                 send_last_q;
  logic                 send_val_q;
  logic                 at_last;
  logic                 send_hs;
  logic                 recv_hs;

  assign idx_nxt = idx + IDX_W'(1);
  assign at_last = (idx == LAST_IDX);
  assign send_hs = send_val_q & intf.send_rdy;

  // Ready when empty, or when the final bin is leaving this very cycle.
  assign intf.recv_rdy = (state == IDLE) | ((state == SEND) & at_last & intf.send_rdy);
  assign recv_hs       = intf.recv_val & intf.recv_rdy;

  assign intf.send_msg  = send_msg_q;
  assign intf.send_idx  = idx;
  assign intf.send_last = send_last_q;
  assign intf.send_val  = send_val_q;

  // Frame capture, bin sequencing and registered sample outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      send_msg_q  <= '0;
      send_last_q <= 1'b0;
      send_val_q  <= 1'b0;
      for (int k = 0; k < N_SAMPLES; k++) frame[k] <= '0;
    end else if (recv_hs) begin
      // New frame: from IDLE, or chained behind the last bin of the previous one.
      state       <= SEND;
      frame       <= intf.recv_msg;
      idx         <= '0;
      send_msg_q  <= intf.recv_msg[0];
      send_last_q <= 1'b0;
      send_val_q  <= 1'b1;
    end else if (send_hs) begin
      if (at_last) begin
        state       <= IDLE;
        idx         <= '0;
        send_msg_q  <= '0;
        send_last_q <= 1'b0;
        send_val_q  <= 1'b0;
      end else begin
        idx         <= idx_nxt;
        send_msg_q  <= frame[idx_nxt];
        send_last_q <= (idx_nxt == LAST_IDX);
      end
    end
  end
endmodule

// File: tb/tb_fft_output_serializer.sv
// Scoreboard bench: stimulus pushes expected beats, per-DUT monitors pop on each send handshake.
module tb_fft_output_serializer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_output_serializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) ifa ();
  fft_output_serializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) ifb ();
  fft_output_serializer_if #(.BIT_WIDTH(32), .N_SAMPLES(2)) ifc ();

  fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .HALF_SPECTRUM(0)) dut_a (.clk(clk), .reset(reset), .intf(ifa));
  fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .HALF_SPECTRUM(1)) dut_b (.clk(clk), .reset(reset), .intf(ifb));
  fft_output_serializer #(.BIT_WIDTH(32), .N_SAMPLES(2), .HALF_SPECTRUM(0)) dut_c (.clk(clk), .reset(reset), .intf(ifc));

  typedef struct {
    logic [31:0] msg;
    int          idx;
    logic        last;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];
  beat_t ea, eb, ec;
  int    na, nb, nc;
  int    checks = 0;
  int    errors = 0;

  function automatic beat_t mk(input logic [31:0] m, input int i, input logic l);
    beat_t b;
    b.msg  = m;
    b.idx  = i;
    b.last = l;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic mon_beat(input string nm, input int qsz, input beat_t e,
                          input logic [31:0] m, input int i, input logic l);
    if (qsz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_beat: got idx %0d msg %0h, required no beat", nm, i, m);
    end else begin
      chk({nm, "_msg"}, m, e.msg);
      chk({nm, "_idx"}, i, e.idx);
      chk({nm, "_last"}, l, e.last);
    end
  endtask

  // Monitors: one pop per accepted beat, compared against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && ifa.send_val === 1'b1 && ifa.send_rdy === 1'b1) begin
      na = qa.size();
      if (na > 0) ea = qa.pop_front();
      mon_beat("a", na, ea, ifa.send_msg, int'(ifa.send_idx), ifa.send_last);
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && ifb.send_val === 1'b1 && ifb.send_rdy === 1'b1) begin
      nb = qb.size();
      if (nb > 0) eb = qb.pop_front();
      mon_beat("b", nb, eb, ifb.send_msg, int'(ifb.send_idx), ifb.send_last);
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b1 && ifc.send_val === 1'b1 && ifc.send_rdy === 1'b1) begin
      nc = qc.size();
      if (nc > 0) ec = qc.pop_front();
      mon_beat("c", nc, ec, ifc.send_msg, int'(ifc.send_idx), ifc.send_last);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_idle(input string nm);
    @(negedge clk);
    chk({nm, "_send_val"}, ifa.send_val, 1'b0);
    chk({nm, "_recv_rdy"}, ifa.recv_rdy, 1'b1);
    chk({nm, "_send_msg"}, ifa.send_msg, 32'h0);
    chk({nm, "_send_idx"}, ifa.send_idx, 3'd0);
    chk({nm, "_send_last"}, ifa.send_last, 1'b0);
  endtask

  logic [31:0] frm_a [8];
  logic [31:0] frm_b [8];
  int beats;

  initial begin
    reset = 1'b0;
    ifa.recv_val = 1'b0; ifa.send_rdy = 1'b1;
    ifb.recv_val = 1'b0; ifb.send_rdy = 1'b1;
    ifc.recv_val = 1'b0; ifc.send_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ifa.recv_msg[k] = 32'h0;
      ifb.recv_msg[k] = 32'h0;
    end
    for (int k = 0; k < 2; k++) ifc.recv_msg[k] = 32'h0;

    // Reset state, sampled between edges.
    #12;
    chk("rst_a_send_val", ifa.send_val, 1'b0);
    chk("rst_a_recv_rdy", ifa.recv_rdy, 1'b1);
    chk("rst_a_send_msg", ifa.send_msg, 32'h0);
    chk("rst_a_send_idx", ifa.send_idx, 3'd0);
    chk("rst_a_send_last", ifa.send_last, 1'b0);
    chk("rst_b_send_val", ifb.send_val, 1'b0);
    chk("rst_c_send_val", ifc.send_val, 1'b0);

    // Single frame k*0x10000, offered before release so the first edge takes it.
    for (int k = 0; k < 8; k++) begin
      ifa.recv_msg[k] = 32'h0001_0000 * k;
      qa.push_back(mk(32'h0001_0000 * k, k, k == 7));
    end
    ifa.recv_val = 1'b1;
    #1 reset = 1'b1;
    tick();
    ifa.recv_val = 1'b0;
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      chk("single_send_val", ifa.send_val, 1'b1);
      chk("single_recv_rdy", ifa.recv_rdy, b == 7);
      tick();
    end
    chk_a_idle("single_end");

    // Back-to-back frames A then B with recv_val held high.
    tick();
    for (int k = 0; k < 8; k++) begin
      frm_a[k] = 32'hA000_0000 + k;
      frm_b[k] = 32'hB000_0000 + k;
      ifa.recv_msg[k] = frm_a[k];
    end
    for (int k = 0; k < 8; k++) qa.push_back(mk(frm_a[k], k, k == 7));
    for (int k = 0; k < 8; k++) qa.push_back(mk(frm_b[k], k, k == 7));
    ifa.recv_val = 1'b1;
    tick();
    for (int k = 0; k < 8; k++) ifa.recv_msg[k] = frm_b[k];
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      chk("b2b_send_val", ifa.send_val, 1'b1);
      chk("b2b_recv_rdy", ifa.recv_rdy, (b % 8) == 7);
      tick();
      if (b == 7) ifa.recv_val = 1'b0;
    end
    chk_a_idle("b2b_end");

    // Stalls with send_rdy pattern 1,0,0,1 and recv_msg churn mid-frame.
    tick();
    for (int k = 0; k < 8; k++) begin
      frm_a[k] = 32'hC000_0000 + 32'(k * 3);
      ifa.recv_msg[k] = frm_a[k];
      qa.push_back(mk(frm_a[k], k, k == 7));
    end
    ifa.recv_val = 1'b1;
    tick();
    ifa.recv_val = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 8; c++) begin
      ifa.send_rdy = ((c % 4) == 0) || ((c % 4) == 3);
      for (int k = 0; k < 8; k++) ifa.recv_msg[k] = $urandom;
      @(negedge clk);
      chk("stall_send_val", ifa.send_val, 1'b1);
      chk("stall_hold_idx", ifa.send_idx, beats);
      chk("stall_hold_msg", ifa.send_msg, frm_a[beats]);
      if (ifa.send_rdy) beats++;
      tick();
    end
    chk("stall_beat_count", beats, 8);
    ifa.send_rdy = 1'b1;
    chk_a_idle("stall_end");

    // Asynchronous reset after beat 3 of a frame.
    tick();
    for (int k = 0; k < 8; k++) ifa.recv_msg[k] = 32'hD000_0000 + k;
    for (int k = 0; k < 4; k++) qa.push_back(mk(32'hD000_0000 + k, k, 1'b0));
    ifa.recv_val = 1'b1;
    tick();
    ifa.recv_val = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("rstmid_send_val", ifa.send_val, 1'b1);
      tick();
    end
    #2 reset = 1'b0;
    #1;
    chk("rstmid_send_val_now", ifa.send_val, 1'b0);
    chk("rstmid_recv_rdy_now", ifa.recv_rdy, 1'b1);
    chk("rstmid_send_msg_now", ifa.send_msg, 32'h0);
    chk("rstmid_send_idx_now", ifa.send_idx, 3'd0);
    chk("rstmid_send_last_now", ifa.send_last, 1'b0);
    #10 reset = 1'b1;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("rstmid_no_residual", ifa.send_val, 1'b0);
    end

    // Half spectrum: bins 0..4 only.
    tick();
    for (int k = 0; k < 8; k++) ifb.recv_msg[k] = 32'(10 + k);
    for (int k = 0; k < 5; k++) qb.push_back(mk(32'(10 + k), k, k == 4));
    ifb.recv_val = 1'b1;
    tick();
    ifb.recv_val = 1'b0;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      chk("half_send_val", ifb.send_val, 1'b1);
      chk("half_send_last", ifb.send_last, b == 4);
      tick();
    end
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk("half_no_upper_bins", ifb.send_val, 1'b0);
    end

    // N=2 extremes, bit-exact.
    tick();
    ifc.recv_msg[0] = 32'hFFFF_0000;
    ifc.recv_msg[1] = 32'h7FFF_FFFF;
    qc.push_back(mk(32'hFFFF_0000, 0, 1'b0));
    qc.push_back(mk(32'h7FFF_FFFF, 1, 1'b1));
    ifc.recv_val = 1'b1;
    tick();
    ifc.recv_val = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("n2_send_val", ifc.send_val, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("n2_idle", ifc.send_val, 1'b0);

    repeat (2) tick();
    chk("a_pending", qa.size(), 0);
    chk("b_pending", qb.size(), 0);
    chk("c_pending", qc.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_output_serializer.md
FFT_OUTPUT_SERIALIZER -- requirements
Module: fft_output_serializer

Interface
REQ-001 Parameter BIT_WIDTH, default 32, sets the width of one sample word.
REQ-002 Parameter N_SAMPLES, default 8, sets the frame size; it SHALL be a power of two, >= 2.
REQ-003 Parameter HALF_SPECTRUM, default 0; when 1, only bins 0..N_SAMPLES/2 are emitted (real-input symmetry).
REQ-004 Derived value OUT_COUNT SHALL be N_SAMPLES when HALF_SPECTRUM=0, and N_SAMPLES/2+1 when HALF_SPECTRUM=1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-007 recv_msg  input  BIT_WIDTH x N_SAMPLES  unpacked array holding one parallel frame; element k is bin k.
REQ-008 recv_val  input  1  frame on recv_msg is valid.
REQ-009 recv_rdy  output  1  block can accept a frame this cycle.
REQ-010 send_msg  output  BIT_WIDTH  current serial sample.
REQ-011 send_idx  output  $clog2(N_SAMPLES)  bin index of send_msg.
REQ-012 send_last  output  1  high when send_idx = OUT_COUNT-1.
REQ-013 send_val  output  1  send_msg/send_idx/send_last are valid.
REQ-014 send_rdy  input  1  downstream accepts the current sample.

Function
REQ-015 The FSM SHALL have two states: IDLE and SEND.
REQ-016 A recv handshake (recv_val & recv_rdy at a rising edge) SHALL capture all N_SAMPLES words into the frame register, clear idx to 0, and enter SEND.
REQ-017 recv_rdy SHALL be 1 in IDLE, and 0 in SEND except when idx = OUT_COUNT-1 and send_rdy = 1.
REQ-018 In that exception cycle, recv_rdy SHALL be combinational from send_rdy, enabling back-to-back frames.
REQ-019 send_val SHALL be 1 exactly in SEND; send_msg SHALL be frame[idx] and send_idx SHALL be idx, both driven from registers with no combinational path from recv_msg.
REQ-020 A send handshake (send_val & send_rdy) with idx < OUT_COUNT-1 SHALL increment idx by 1.
REQ-021 A send handshake at idx = OUT_COUNT-1 with recv_val = 1 SHALL load the new frame, set idx to 0 and remain in SEND, with no idle cycle.
REQ-022 A send handshake at idx = OUT_COUNT-1 with recv_val = 0 SHALL go to IDLE and set idx to 0.
REQ-023 With send_rdy = 0, idx, frame, send_msg and send_val SHALL hold unchanged (no drop, no duplicate).
REQ-024 Changes on recv_msg while in SEND and not handshaking SHALL NOT affect the frame register.
REQ-025 Latency: first sample valid on the cycle after the recv handshake; sustained throughput is one sample per cycle when send_rdy is held 1.
REQ-026 With HALF_SPECTRUM=1, bins N_SAMPLES/2+1..N_SAMPLES-1 SHALL never be emitted; send_last SHALL be asserted at bin N_SAMPLES/2.
REQ-027 Data SHALL pass bit-exact with no arithmetic, sign change or width change.
REQ-028 In IDLE, send_msg, send_idx and send_last SHALL read 0.

Reset
REQ-029 While reset = 0 the state SHALL asynchronously become IDLE, with idx = 0, frame = all 0, send_val = 0, send_last = 0, send_msg = 0, send_idx = 0 and recv_rdy = 1.
REQ-030 Reset asserted mid-frame SHALL discard the remaining samples; after release, no residual sample is emitted.
REQ-031 The first recv handshake SHALL be accepted on the first rising edge after reset returns to 1.

Verification
REQ-032 N=8, HALF=0, frame {0x00010000*k}, send_rdy=1 -> 8 consecutive beats k=0..7 with those values; send_last only on k=7; then recv_rdy=1 and send_val=0.
REQ-033 Two frames A, B with recv_val held 1 and send_rdy=1 -> 16 beats with no gap; B0 appears on the cycle after A7; recv_rdy pulses only with the A7 handshake.
REQ-034 send_rdy toggling 1,0,0,1,... during a frame -> each bin appears exactly once in order, holding stable while send_rdy=0; recv_msg changes mid-frame have no effect.
REQ-035 N=8, HALF=1, frame {10,11,...,17} -> 5 beats with values 10..14 and idx 0..4; send_last at idx 4; bins 5..7 are never driven valid.
REQ-036 Reset driven to 0 asynchronously (between edges) after beat 3 -> outputs go to reset values immediately; after release, send_val stays 0 until a new recv handshake.
REQ-037 N=2, HALF=0, single frame {0xFFFF0000, 0x7FFFFFFF} -> 2 beats bit-exact with send_last on idx 1.
